// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle fetch/decode/execute sequencer with halt, run,
//            single-step and run-to-breakpoint modes plus a debug display.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int DISP_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic               step,
    input  logic [PC_W-1:0]    bkpt_addr,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic [PC_W-1:0]    exec_nextpc,
    input  logic               exec_halt,
    input  logic [31:0]        regvalue,
    input  logic [1:0]         disp_sel,
    output logic [DISP_W-1:0]  short_display,
    output logic [2:0]         state,
    output logic [15:0]        retired,
    output logic               halted
);

    localparam logic [PC_W-1:0] c_RESET_PC = PC_W'(RESET_PC);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [1:0] c_MODE_HALT = 2'b00;
    localparam logic [1:0] c_MODE_RUN  = 2'b01;
    localparam logic [1:0] c_MODE_STEP = 2'b10;
    localparam logic [1:0] c_MODE_BKPT = 2'b11;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [15:0]        r_retired;
    logic               r_step_q;
    logic               r_exec_seen;
    logic [DISP_W-1:0]  r_display;

    logic               w_step_edge;
    logic               w_at_bkpt;
    logic               w_idle_go;
    logic               w_wb_go;
    logic               w_retire;
    logic [31:0]        w_pc_ext;
    logic [31:0]        w_ir_ext;
    logic [31:0]        w_ret_ext;
    logic [31:0]        w_disp_wide;
    logic               w_unused_bits;

    assign w_step_edge = step & ~r_step_q;
    assign w_at_bkpt   = (r_pc == bkpt_addr);
    assign w_retire    = (r_state == c_ST_EXEC) && exec_done;

    // Mode is only consulted at instruction boundaries (IDLE and WB).
    always_comb begin
        w_idle_go = 1'b0;
        w_wb_go   = 1'b0;
        case (mode)
            c_MODE_RUN: begin
                w_idle_go = 1'b1;
                w_wb_go   = 1'b1;
            end
            c_MODE_STEP: begin
                w_idle_go = w_step_edge;
            end
            c_MODE_BKPT: begin
                w_idle_go = ~w_at_bkpt | w_step_edge;
                w_wb_go   = ~w_at_bkpt;
            end
            c_MODE_HALT: begin
                w_idle_go = 1'b0;
            end
            default: begin
                w_idle_go = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_idle_go) w_next_state = c_ST_FETCH;
            c_ST_FETCH:  if (imem_ack)  w_next_state = c_ST_DECODE;
            c_ST_DECODE: w_next_state = c_ST_EXEC;
            c_ST_EXEC:   if (exec_done) w_next_state = exec_halt ? c_ST_HALT : c_ST_WB;
            c_ST_WB:     w_next_state = w_wb_go ? c_ST_FETCH : c_ST_IDLE;
            c_ST_HALT:   w_next_state = c_ST_HALT;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (r_state == c_ST_FETCH);
        exec_start = (r_state == c_ST_EXEC) && !r_exec_seen;
        halted     = (r_state == c_ST_HALT);
    end

    // Retirement is counted as the instruction completes, so WB and HALT
    // both already show the updated count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc        <= c_RESET_PC;
            r_ir        <= '0;
            r_retired   <= '0;
            r_step_q    <= 1'b0;
            r_exec_seen <= 1'b0;
            r_display   <= '0;
        end else begin
            r_step_q    <= step;
            r_exec_seen <= (r_state == c_ST_EXEC);
            r_display   <= w_disp_wide[DISP_W-1:0];
            if ((r_state == c_ST_FETCH) && imem_ack) begin
                r_ir <= imem_data;
            end
            if (w_retire) begin
                r_pc      <= exec_nextpc;
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    generate
        if (PC_W < 32) begin : g_pc_narrow
            assign w_pc_ext = {{(32-PC_W){1'b0}}, r_pc};
        end else begin : g_pc_wide
            assign w_pc_ext = r_pc[31:0];
        end
        if (INSTR_W < 32) begin : g_ir_narrow
            assign w_ir_ext = {{(32-INSTR_W){1'b0}}, r_ir};
        end else begin : g_ir_wide
            assign w_ir_ext = r_ir[31:0];
        end
    endgenerate

    assign w_ret_ext = {16'h0000, r_retired};

    always_comb begin
        w_disp_wide = '0;
        case (disp_sel)
            2'b00:   w_disp_wide = regvalue;
            2'b01:   w_disp_wide = w_pc_ext;
            2'b10:   w_disp_wide = w_ret_ext;
            default: w_disp_wide = w_ir_ext;
        endcase
    end

    // Bits above DISP_W are intentionally dropped from the display.
    assign w_unused_bits = ^w_disp_wide;

    assign imem_addr     = r_pc;
    assign ir            = r_ir;
    assign state         = r_state;
    assign retired       = r_retired;
    assign short_display = r_display;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int DISP_W  = 16;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         mode = 2'b00;
    logic               step = 1'b0;
    logic [PC_W-1:0]    bkpt_addr = '0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_data = '0;
    logic [INSTR_W-1:0] ir;
    logic               exec_start;
    logic               exec_done = 1'b0;
    logic [PC_W-1:0]    exec_nextpc = '0;
    logic               exec_halt = 1'b0;
    logic [31:0]        regvalue = '0;
    logic [1:0]         disp_sel = 2'b00;
    logic [DISP_W-1:0]  short_display;
    logic [2:0]         state;
    logic [15:0]        retired;
    logic               halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment knobs: fixed wait (>=0) or random wait up to max.
    int fetch_fixed = 0;
    int fetch_max   = 0;
    int exec_fixed  = 0;
    int exec_max    = 0;
    bit spurious    = 1'b0;

    logic [31:0] mem [256];

    // Reference model state (instruction level).
    logic [7:0]  m_pc;
    logic [15:0] m_count;
    bit          m_started;
    bit          m_prev_halted;

    cpu_sequencer #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DISP_W(DISP_W), .RESET_PC(0)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .step(step),
        .bkpt_addr(bkpt_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir),
        .exec_start(exec_start), .exec_done(exec_done),
        .exec_nextpc(exec_nextpc), .exec_halt(exec_halt),
        .regvalue(regvalue), .disp_sel(disp_sel),
        .short_display(short_display), .state(state),
        .retired(retired), .halted(halted)
    );

    initial forever #5 clock = ~clock;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bench instruction encoding: [31:24]==FF halt, [8] jump, [7:0] target.
    function automatic logic [7:0] ref_next(input logic [31:0] instr, input logic [7:0] pc);
        return instr[8] ? instr[7:0] : 8'(pc + 8'd1);
    endfunction

    function automatic bit ref_halt(input logic [31:0] instr);
        return instr[31:24] == 8'hFF;
    endfunction

    function automatic logic [31:0] mk_seq();
        return {8'($urandom_range(254, 0)), 15'($urandom), 1'b0, 8'($urandom)};
    endfunction

    function automatic logic [31:0] mk_jmp(input logic [7:0] target);
        return {8'($urandom_range(254, 0)), 15'($urandom), 1'b1, target};
    endfunction

    function automatic int pick_wait(input int fixed, input int maxw);
        return (fixed >= 0) ? fixed : int'($urandom_range(maxw, 0));
    endfunction

    task automatic fill_seq();
        for (int i = 0; i < 256; i++) mem[i] = mk_seq();
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(3, 0) == 0) ? mk_jmp(8'($urandom)) : mk_seq();
    endtask

    // Instruction memory responder.
    initial begin : imem_model
        int busy;
        int cnt;
        busy = 0;
        cnt  = 0;
        forever begin
            @(negedge clock);
            if (reset || !imem_req) begin
                busy      = 0;
                imem_ack  = spurious && ($urandom_range(3, 0) == 0);
                imem_data = $urandom;
            end else begin
                if (busy == 0) begin
                    busy = 1;
                    cnt  = pick_wait(fetch_fixed, fetch_max);
                end
                if (cnt == 0) begin
                    imem_ack  = 1'b1;
                    imem_data = mem[imem_addr];
                    busy      = 0;
                end else begin
                    imem_ack  = 1'b0;
                    imem_data = $urandom;
                    cnt--;
                end
            end
        end
    end

    // Execution unit responder.
    initial begin : exec_model
        int busy;
        int cnt;
        busy = 0;
        cnt  = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy      = 0;
                exec_done = 1'b0;
            end else begin
                if (exec_start) begin
                    busy = 1;
                    cnt  = pick_wait(exec_fixed, exec_max);
                end
                if (busy != 0 && cnt == 0) begin
                    exec_done   = 1'b1;
                    exec_nextpc = ref_next(ir, imem_addr);
                    exec_halt   = ref_halt(ir);
                    busy        = 0;
                end else begin
                    if (busy != 0) cnt--;
                    exec_done   = (busy == 0) && spurious && ($urandom_range(3, 0) == 0);
                    exec_nextpc = 8'($urandom);
                    exec_halt   = 1'($urandom_range(1, 0));
                end
            end
        end
    end

    // Instruction-level scoreboard: every fetch, start and retirement.
    initial begin : monitor
        bit       exp_halt;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_pc          = 8'h00;
                m_count       = 16'h0000;
                m_started     = 1'b0;
                m_prev_halted = 1'b0;
            end else begin
                if (imem_req) check_value("fetch_addr", imem_addr, m_pc);
                if (exec_start) begin
                    check_value("start_once", m_started, 0);
                    check_value("ir_latched", ir, mem[m_pc]);
                    check_value("exec_pc", imem_addr, m_pc);
                    m_started = 1'b1;
                end
                if (state == c_ST_WB || (halted && !m_prev_halted)) begin
                    exp_halt = ref_halt(mem[m_pc]);
                    m_pc     = ref_next(mem[m_pc], m_pc);
                    m_count  = m_count + 16'd1;
                    check_value("retire_after_start", m_started, 1);
                    check_value("retire_state", state, exp_halt ? c_ST_HALT : c_ST_WB);
                    check_value("retired", retired, m_count);
                    check_value("retire_pc", imem_addr, m_pc);
                    m_started = 1'b0;
                end
                m_prev_halted = halted;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_state"}, state, c_ST_IDLE);
        check_value({tag, "_imem_req"}, imem_req, 0);
        check_value({tag, "_exec_start"}, exec_start, 0);
        check_value({tag, "_retired"}, retired, 0);
        check_value({tag, "_halted"}, halted, 0);
        check_value({tag, "_display"}, short_display, 0);
        check_value({tag, "_ir"}, ir, 0);
        check_value({tag, "_pc"}, imem_addr, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (state !== c_ST_IDLE && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_value(tag, state, c_ST_IDLE);
    endtask

    task automatic test_timing();
        int edges = 0;
        fill_seq();
        fetch_fixed = 0; exec_fixed = 0; spurious = 1'b1; mode = 2'b01;
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            while (edges < 4 * k) begin
                @(posedge clock);
                edges++;
            end
            #1;
            check_value("t1_retired", retired, k);
            check_value("t1_pc", imem_addr, k);
            check_value("t1_state", state, c_ST_WB);
        end
        @(negedge clock);
        mode = 2'b00;
        wait_idle("t1_idle", 50);
    endtask

    task automatic test_fetch_wait();
        int fc = 0;
        int bad = 0;
        int n = 0;
        fill_seq();
        fetch_fixed = 3; exec_fixed = -1; exec_max = 2; mode = 2'b01;
        apply_reset();
        while (state !== c_ST_DECODE && n < 20) begin
            @(negedge clock);
            n++;
            if (state == c_ST_FETCH) begin
                fc++;
                if (imem_addr !== 8'h00 || ir !== 32'h0) bad++;
            end
        end
        check_value("t2_fetch_cycles", fc, 4);
        check_value("t2_fetch_stable", bad, 0);
        check_value("t2_ir", ir, mem[0]);
        repeat (30) @(negedge clock);
        mode = 2'b00;
        wait_idle("t2_idle", 50);
    endtask

    task automatic test_step();
        logic [15:0] exp_d [4];
        fill_seq();
        fetch_fixed = -1; fetch_max = 3; exec_fixed = -1; exec_max = 3;
        mode = 2'b10; step = 1'b0;
        apply_reset();
        repeat (5) @(negedge clock);
        check_value("t3_idle0", state, c_ST_IDLE);
        check_value("t3_retired0", retired, 0);
        step = 1'b1;
        repeat (20) @(negedge clock);
        check_value("t3_retired1", retired, 1);
        check_value("t3_pc1", imem_addr, 1);
        check_value("t3_idle1", state, c_ST_IDLE);
        step = 1'b0;
        repeat (3) @(negedge clock);
        step = 1'b1;
        repeat (20) @(negedge clock);
        check_value("t3_retired2", retired, 2);
        check_value("t3_pc2", imem_addr, 2);
        step = 1'b0;
        regvalue = $urandom;
        exp_d[0] = regvalue[15:0];
        exp_d[1] = 16'h0002;
        exp_d[2] = 16'h0002;
        exp_d[3] = mem[1][15:0];
        for (int s = 0; s < 4; s++) begin
            disp_sel = 2'(s);
            repeat (2) @(negedge clock);
            check_value($sformatf("t3_disp_sel%0d", s), short_display, exp_d[s]);
        end
        disp_sel = 2'b00;
    endtask

    task automatic test_breakpoint();
        int n = 0;
        fill_seq();
        mode = 2'b11; bkpt_addr = 8'h05; step = 1'b0;
        apply_reset();
        while (state === c_ST_IDLE && n < 20) begin @(negedge clock); n++; end
        wait_idle("t4_stop", 300);
        check_value("t4_retired", retired, 5);
        check_value("t4_pc", imem_addr, 5);
        repeat (10) @(negedge clock);
        check_value("t4_hold", state, c_ST_IDLE);
        step = 1'b1;
        repeat (2) @(negedge clock);
        step = 1'b0;
        repeat (40) @(negedge clock);
        check_value("t4_running", retired > 16'd7, 1);
        wait_idle("t4_stop2", 4000);
        check_value("t4_retired_wrap", retired, 261);
        check_value("t4_pc_wrap", imem_addr, 5);
        mode = 2'b00;
    endtask

    task automatic test_halt();
        int n = 0;
        int bad = 0;
        fill_seq();
        mem[3] = {8'hFF, 15'($urandom), 1'b0, 8'($urandom)};
        mode = 2'b01;
        apply_reset();
        while (!halted && n < 200) begin @(negedge clock); n++; end
        check_value("t5_halted", halted, 1);
        check_value("t5_state", state, c_ST_HALT);
        check_value("t5_retired", retired, 4);
        for (int i = 0; i < 30; i++) begin
            mode      = 2'($urandom);
            step      = 1'($urandom_range(1, 0));
            bkpt_addr = 8'($urandom);
            @(negedge clock);
            if (state !== c_ST_HALT || imem_req || exec_start || retired !== 16'd4) bad++;
        end
        check_value("t5_stuck", bad, 0);
        reset = 1'b1;
        #1;
        check_reset_values("t5_reset");
        mode = 2'b00; step = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_wrap_and_abort();
        int n = 0;
        fill_seq();
        mem[0] = mk_jmp(8'hFF);
        disp_sel = 2'b01; mode = 2'b01;
        fetch_fixed = -1; exec_fixed = -1;
        apply_reset();
        while (!(state === c_ST_WB && retired === 16'd1) && n < 60) begin @(negedge clock); n++; end
        check_value("t6_pc_ff", imem_addr, 8'hFF);
        @(negedge clock);
        check_value("t6_disp_ff", short_display, 16'h00FF);
        n = 0;
        while (!(state === c_ST_WB && retired === 16'd2) && n < 60) begin @(negedge clock); n++; end
        check_value("t6_pc_wrap", imem_addr, 8'h00);
        @(negedge clock);
        check_value("t6_disp_wrap", short_display, 16'h0000);
        exec_fixed = 4;
        n = 0;
        while (!exec_start && n < 60) begin @(negedge clock); n++; end
        check_value("t6_in_exec", exec_start, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_reset");
        mode = 2'b00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exec_fixed = -1;
        repeat (8) @(negedge clock);
        check_value("t6_after_retired", retired, 0);
        check_value("t6_after_state", state, c_ST_IDLE);
        disp_sel = 2'b00;
    endtask

    task automatic test_random(input int zero_wait);
        int busy = 0;
        fill_rand();
        fetch_fixed = zero_wait ? 0 : -1; fetch_max = 3;
        exec_fixed  = zero_wait ? 0 : -1; exec_max  = 3;
        spurious = 1'b1; mode = 2'b01; bkpt_addr = 8'($urandom);
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            if ($urandom_range(15, 0) == 0) mode = 2'($urandom);
            if ($urandom_range(3, 0) == 0) step = ~step;
            if ($urandom_range(31, 0) == 0) bkpt_addr = 8'($urandom);
            regvalue = $urandom;
        end
        mode = 2'b00; step = 1'b0;
        wait_idle("t7_idle", 50);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (imem_req) busy++;
        end
        check_value("t7_no_fetch_in_halt_mode", busy, 0);
        check_value("t7_retired_total", retired, m_count);
        check_value("t7_final_pc", imem_addr, m_pc);
    endtask

    initial begin : main
        fill_seq();
        repeat (2) @(negedge clock);
        check_reset_values("por");
        test_timing();
        test_fetch_wait();
        test_step();
        test_breakpoint();
        test_halt();
        test_wrap_and_abort();
        test_random(1);
        test_random(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
